fifo_mem_ctrl: RTL
==================

// Module: fifo_mem_ctrl
// PURPOSE
//   Pointer/flag controller driving the dual-port ram (write, read, addr_write, addr_read) as a FIFO.
//   Accepts push/pop from the producer and consumer, generates RAM port strobes and addresses, and tracks occupancy.
//   Flags full, empty and almost-full/almost-empty against programmable thresholds.
//   Issues data_valid aligned with the RAM's 1-cycle registered data_out; one instance per FIFO in the integration.
// PARAMETERS
//   ADDR_BITS  3   RAM address width; depth DEPTH = 2**ADDR_BITS (8 entries)
// PORTS
//   clk             in   1            single clock, all state on posedge
//   reset           in   1            asynchronous, active-high reset
//   push            in   1            producer requests write of current RAM data_in
//   pop             in   1            consumer requests read of head entry
//   thr_high        in   ADDR_BITS+1  almost_full threshold (entries)
//   thr_low         in   ADDR_BITS+1  almost_empty threshold (entries)
//   ram_write       out  1            to ram.write (combinational)
//   ram_addr_write  out  ADDR_BITS    to ram.addr_write (= wr_ptr)
//   ram_read        out  1            to ram.read (combinational)
//   ram_addr_read   out  ADDR_BITS    to ram.addr_read (= rd_ptr)
//   data_valid      out  1            ram.data_out holds popped word this cycle
//   count           out  ADDR_BITS+1  current occupancy, 0..DEPTH
//   full            out  1            count == DEPTH
//   empty           out  1            count == 0
//   almost_full     out  1            count >= thr_high
//   almost_empty    out  1            count <= thr_low
//   overflow_err    out  1            sticky: push rejected
//   underflow_err   out  1            sticky: pop rejected
// BEHAVIOUR
//   Reset (async, while reset=1): wr_ptr=rd_ptr=0, count=0, data_valid=0, overflow_err=underflow_err=0.
//     Hence empty=1, full=0, almost_empty=1 (thr_low>=0), almost_full=(thr_high==0), ram_write=ram_read=0.
//     Reset mid-operation discards contents; RAM array is not cleared (stale data unreachable).
//   Acceptance, same cycle:
//     pop_ok  = pop & ~empty
//     push_ok = push & (~full | pop_ok)   (push into full FIFO allowed only with accepted pop)
//   RAM drive (combinational): ram_write = push_ok, ram_addr_write = wr_ptr, ram_read = pop_ok, ram_addr_read = rd_ptr.
//     When full and push_ok & pop_ok: wr_ptr == rd_ptr; the RAM returns the old word (read-before-write). This is required.
//   Posedge updates:
//     push_ok: wr_ptr <= wr_ptr+1 (mod DEPTH, natural wrap 7->0)
//     pop_ok:  rd_ptr <= rd_ptr+1 (mod DEPTH)
//     count <= count + push_ok - pop_ok (both -> unchanged)
//     data_valid <= pop_ok; read latency 1 cycle: data on ram.data_out in the cycle after pop_ok.
//   No read-through on empty: push & pop when empty -> push accepted, pop rejected, underflow_err set.
//   Errors: push & ~push_ok -> overflow_err <= 1; pop & ~pop_ok -> underflow_err <= 1. Both cleared only by reset.
//     A rejected request changes no pointer, no count, no RAM strobe.
//   Flags: full, empty, almost_full, almost_empty are combinational decodes of registered count (glitch-free, no extra latency).
//   Thresholds are sampled live; no internal pipeline stages. No other states beyond the pointer/count registers.
// TESTING
//   1. Reset, 8 pushes data 0x001..0x008 -> count 1..8, ram_addr_write 0..7, full=1 after 8th, almost_full once count>=thr_high(6).
//   2. Push with full, pop=0 -> ram_write=0, count stays 8, overflow_err=1 and stays 1.
//   3. 8 pops after test 1 -> data_valid one cycle after each pop, data_out 0x001..0x008 in order, empty=1, then pop -> underflow_err=1.
//   4. Wrap: 6 push, 6 pop, 5 push -> wr_ptr wraps 7->0->3; pops return written data in order.
//   5. Full, push&pop same cycle -> count stays 8, popped word = oldest; empty, push&pop -> count 1, underflow_err=1.
//   6. Assert reset at count 5 mid-stream -> immediately count 0, empty=1, data_valid=0, errors cleared; resume pushes at addr 0.

Source files
------------

// File: rtl/fifo_mem_ctrl_if.sv
// Handshake and flag bundle between a FIFO's producer/consumer side
// and its pointer controller, including the dual-port RAM strobes.
interface fifo_mem_ctrl_if #(
    parameter int ADDR_BITS = 3
);
    logic                 push;
    logic                 pop;
    logic [ADDR_BITS:0]   thr_high;
    logic [ADDR_BITS:0]   thr_low;
    logic                 ram_write;
    logic [ADDR_BITS-1:0] ram_addr_write;
    logic                 ram_read;
    logic [ADDR_BITS-1:0] ram_addr_read;
    logic                 data_valid;
    logic [ADDR_BITS:0]   count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output push, pop, thr_high, thr_low,
        input  ram_write, ram_addr_write, ram_read, ram_addr_read,
        input  data_valid, count, full, empty,
        input  almost_full, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  push, pop, thr_high, thr_low,
        output ram_write, ram_addr_write, ram_read, ram_addr_read,
        output data_valid, count, full, empty,
        output almost_full, almost_empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// FIFO pointer/occupancy controller for an external dual-port RAM with
// a 1-cycle registered read port; flags decode the registered count.
module fifo_mem_ctrl #(
    parameter int ADDR_BITS = 3
) (
    input  logic           clk,
    input  logic           reset,
    fifo_mem_ctrl_if.slave bus
);
    localparam logic [ADDR_BITS:0]   DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 full, empty, push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign pop_ok  = bus.pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = bus.push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = pop_ok;
        ovf_d    = ovf_q | (bus.push & ~push_ok);
        unf_d    = unf_q | (bus.pop & ~pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.ram_write      = push_ok;
    assign bus.ram_addr_write = wr_ptr_q;
    assign bus.ram_read       = pop_ok;
    assign bus.ram_addr_read  = rd_ptr_q;
    assign bus.data_valid     = valid_q;
    assign bus.count          = count_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.almost_full    = (count_q >= bus.thr_high);
    assign bus.almost_empty   = (count_q <= bus.thr_low);
    assign bus.overflow_err   = ovf_q;
    assign bus.underflow_err  = unf_q;
endmodule
